// File: rtl/tl_buffer_cfg.sv
`default_nettype none
// ============================================================================
//  Module   : tl_buffer_cfg (with helper tl_buffer_cfg_queue)
//  Purpose  : Configurable TileLink-UL/UH buffer between a client port
//             (auto_in) and a manager port (auto_out). Independently sized
//             A and D queues with optional flow-through and pipe modes,
//             beat-accurate tracking of outstanding messages, and a drain
//             control that stops new A messages at message boundaries.
//  Ports    : clock, reset (async, active-low)
//             auto_in_a_*  / auto_out_a_*  : A channel, client -> manager
//             auto_out_d_* / auto_in_d_*   : D channel, manager -> client
//             drain_req    : hold off new A messages (bursts finish)
//             idle         : registered; nothing queued, nothing outstanding
//             inflight     : messages awaiting their last D beat
//             a_count, d_count : queue occupancies
//  Revision : 1.0  initial release
// ============================================================================

// ----------------------------------------------------------------------------
// Generic ready/valid FIFO. DEPTH = 0 degenerates to wires.
// ----------------------------------------------------------------------------
module tl_buffer_cfg_queue #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int FLOW  = 0,
    parameter int PIPE  = 0,
    parameter int CNT_W = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enq_valid,
    output logic             enq_ready,
    input  logic [WIDTH-1:0] enq_bits,
    output logic             deq_valid,
    input  logic             deq_ready,
    output logic [WIDTH-1:0] deq_bits,
    output logic [CNT_W-1:0] count
);
    generate
        if (DEPTH == 0) begin : g_wire
            logic w_unused;
            assign w_unused  = clock ^ reset;
            assign deq_valid = enq_valid;
            assign deq_bits  = enq_bits;
            assign enq_ready = deq_ready;
            assign count     = '0;
        end else begin : g_fifo
            localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
            localparam logic [PTR_W-1:0] c_last = PTR_W'(DEPTH - 1);
            localparam logic [CNT_W-1:0] c_full = CNT_W'(DEPTH);

            logic [WIDTH-1:0] r_mem [DEPTH];
            logic [PTR_W-1:0] r_wptr;
            logic [PTR_W-1:0] r_rptr;
            logic [CNT_W-1:0] r_count;
            logic             w_empty;
            logic             w_full;
            logic             w_bypass;
            logic             w_do_enq;
            logic             w_do_deq;

            assign w_empty  = (r_count == '0);
            assign w_full   = (r_count == c_full);
            // Flow mode: an empty queue presents the enqueue side directly.
            assign w_bypass = (FLOW != 0) && w_empty;

            assign deq_valid = w_bypass ? enq_valid : !w_empty;
            assign deq_bits  = w_bypass ? enq_bits  : r_mem[r_rptr];
            assign enq_ready = !w_full || ((PIPE != 0) && deq_ready);

            // A bypassed beat that is consumed immediately is never stored.
            assign w_do_enq = enq_valid && enq_ready && !(w_bypass && deq_ready);
            assign w_do_deq = deq_ready && !w_empty;
            assign count    = r_count;

            always_ff @(posedge clock) begin
                if (w_do_enq) begin
                    r_mem[r_wptr] <= enq_bits;
                end
            end

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    r_wptr  <= '0;
                    r_rptr  <= '0;
                    r_count <= '0;
                end else begin
                    if (w_do_enq) begin
                        r_wptr <= (r_wptr == c_last) ? '0 : r_wptr + 1'b1;
                    end
                    if (w_do_deq) begin
                        r_rptr <= (r_rptr == c_last) ? '0 : r_rptr + 1'b1;
                    end
                    if (w_do_enq && !w_do_deq) begin
                        r_count <= r_count + 1'b1;
                    end else if (!w_do_enq && w_do_deq) begin
                        r_count <= r_count - 1'b1;
                    end
                end
            end
        end
    endgenerate
endmodule

// ----------------------------------------------------------------------------
// Top level
// ----------------------------------------------------------------------------
module tl_buffer_cfg #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 64,
    parameter int SOURCE_W     = 1,
    parameter int SINK_W       = 3,
    parameter int SIZE_W       = 4,
    parameter int A_DEPTH      = 2,
    parameter int D_DEPTH      = 2,
    parameter int A_FLOW       = 0,
    parameter int D_FLOW       = 0,
    parameter int A_PIPE       = 0,
    parameter int D_PIPE       = 0,
    parameter int MAX_INFLIGHT = 4,
    localparam int MASK_W      = DATA_W / 8,
    localparam int INF_W       = $clog2(MAX_INFLIGHT + 1),
    localparam int A_CNT_W     = (A_DEPTH > 0) ? $clog2(A_DEPTH + 1) : 1,
    localparam int D_CNT_W     = (D_DEPTH > 0) ? $clog2(D_DEPTH + 1) : 1
) (
    input  logic                clock,
    input  logic                reset,

    input  logic                auto_in_a_valid,
    output logic                auto_in_a_ready,
    input  logic [2:0]          auto_in_a_bits_opcode,
    input  logic [2:0]          auto_in_a_bits_param,
    input  logic [SIZE_W-1:0]   auto_in_a_bits_size,
    input  logic [SOURCE_W-1:0] auto_in_a_bits_source,
    input  logic [ADDR_W-1:0]   auto_in_a_bits_address,
    input  logic [MASK_W-1:0]   auto_in_a_bits_mask,
    input  logic [DATA_W-1:0]   auto_in_a_bits_data,
    input  logic                auto_in_a_bits_corrupt,

    output logic                auto_in_d_valid,
    input  logic                auto_in_d_ready,
    output logic [2:0]          auto_in_d_bits_opcode,
    output logic [1:0]          auto_in_d_bits_param,
    output logic [SIZE_W-1:0]   auto_in_d_bits_size,
    output logic [SOURCE_W-1:0] auto_in_d_bits_source,
    output logic [SINK_W-1:0]   auto_in_d_bits_sink,
    output logic                auto_in_d_bits_denied,
    output logic [DATA_W-1:0]   auto_in_d_bits_data,
    output logic                auto_in_d_bits_corrupt,

    output logic                auto_out_a_valid,
    input  logic                auto_out_a_ready,
    output logic [2:0]          auto_out_a_bits_opcode,
    output logic [2:0]          auto_out_a_bits_param,
    output logic [SIZE_W-1:0]   auto_out_a_bits_size,
    output logic [SOURCE_W-1:0] auto_out_a_bits_source,
    output logic [ADDR_W-1:0]   auto_out_a_bits_address,
    output logic [MASK_W-1:0]   auto_out_a_bits_mask,
    output logic [DATA_W-1:0]   auto_out_a_bits_data,
    output logic                auto_out_a_bits_corrupt,

    input  logic                auto_out_d_valid,
    output logic                auto_out_d_ready,
    input  logic [2:0]          auto_out_d_bits_opcode,
    input  logic [1:0]          auto_out_d_bits_param,
    input  logic [SIZE_W-1:0]   auto_out_d_bits_size,
    input  logic [SOURCE_W-1:0] auto_out_d_bits_source,
    input  logic [SINK_W-1:0]   auto_out_d_bits_sink,
    input  logic                auto_out_d_bits_denied,
    input  logic [DATA_W-1:0]   auto_out_d_bits_data,
    input  logic                auto_out_d_bits_corrupt,

    input  logic                drain_req,
    output logic                idle,
    output logic [INF_W-1:0]    inflight,
    output logic [A_CNT_W-1:0]  a_count,
    output logic [D_CNT_W-1:0]  d_count
);
    localparam int BEAT_LG = $clog2(DATA_W / 8);
    localparam int A_W     = 3 + 3 + SIZE_W + SOURCE_W + ADDR_W + MASK_W + DATA_W + 1;
    localparam int D_W     = 3 + 2 + SIZE_W + SOURCE_W + SINK_W + 1 + DATA_W + 1;
    // Wide enough for the remaining-beat count of the largest encodable size.
    localparam int BEAT_W  = 1 << SIZE_W;

    localparam logic [SIZE_W-1:0] c_beat_lg      = SIZE_W'(BEAT_LG);
    localparam logic [INF_W-1:0]  c_max_inflight = INF_W'(MAX_INFLIGHT);

    // Beats in a message, minus one.
    function automatic logic [BEAT_W-1:0] beats_m1(input logic has_data,
                                                   input logic [SIZE_W-1:0] size);
        logic [BEAT_W-1:0] v;
        v = '0;
        if (has_data && (size > c_beat_lg)) begin
            v = (BEAT_W'(1) << (size - c_beat_lg)) - BEAT_W'(1);
        end
        return v;
    endfunction

    logic [A_W-1:0]    w_a_enq_bits;
    logic [A_W-1:0]    w_a_deq_bits;
    logic [D_W-1:0]    w_d_enq_bits;
    logic [D_W-1:0]    w_d_deq_bits;
    logic              w_aq_enq_ready;
    logic              w_gate;
    logic              w_a_fire;
    logic              w_a_first;
    logic [BEAT_W-1:0] w_a_m1;
    logic              w_d_fire;
    logic              w_d_first;
    logic              w_d_last;
    logic [BEAT_W-1:0] w_d_m1;
    logic              w_inc;
    logic              w_dec;
    logic              w_inflight_full;

    logic [BEAT_W-1:0] r_a_left;
    logic [BEAT_W-1:0] r_d_left;
    logic [INF_W-1:0]  r_inflight;
    logic              r_idle;

    assign w_a_enq_bits = {auto_in_a_bits_opcode, auto_in_a_bits_param, auto_in_a_bits_size,
                           auto_in_a_bits_source, auto_in_a_bits_address, auto_in_a_bits_mask,
                           auto_in_a_bits_data, auto_in_a_bits_corrupt};
    assign {auto_out_a_bits_opcode, auto_out_a_bits_param, auto_out_a_bits_size,
            auto_out_a_bits_source, auto_out_a_bits_address, auto_out_a_bits_mask,
            auto_out_a_bits_data, auto_out_a_bits_corrupt} = w_a_deq_bits;

    assign w_d_enq_bits = {auto_out_d_bits_opcode, auto_out_d_bits_param, auto_out_d_bits_size,
                           auto_out_d_bits_source, auto_out_d_bits_sink, auto_out_d_bits_denied,
                           auto_out_d_bits_data, auto_out_d_bits_corrupt};
    assign {auto_in_d_bits_opcode, auto_in_d_bits_param, auto_in_d_bits_size,
            auto_in_d_bits_source, auto_in_d_bits_sink, auto_in_d_bits_denied,
            auto_in_d_bits_data, auto_in_d_bits_corrupt} = w_d_deq_bits;

    // ---------------- beat framing ----------------
    assign w_a_first = (r_a_left == '0);
    assign w_a_m1    = beats_m1(auto_in_a_bits_opcode <= 3'd3, auto_in_a_bits_size);
    assign w_a_fire  = auto_in_a_valid && auto_in_a_ready;

    assign w_d_first = (r_d_left == '0);
    assign w_d_m1    = beats_m1(auto_in_d_bits_opcode[0], auto_in_d_bits_size);
    assign w_d_last  = w_d_first ? (w_d_m1 == '0) : (r_d_left == BEAT_W'(1));
    assign w_d_fire  = auto_in_d_valid && auto_in_d_ready;

    assign w_inc = w_a_fire && w_a_first;
    // A stray completion with nothing outstanding is ignored (no underflow).
    assign w_dec = w_d_fire && w_d_last && (r_inflight != '0);

    // A completion retiring this cycle frees a slot for a new message in
    // the same cycle, so a full tracker does not cost a bubble.
    assign w_inflight_full = (r_inflight == c_max_inflight) && !w_dec;

    // Only first beats are held off; a burst in progress always completes.
    assign w_gate          = w_a_first && (drain_req || w_inflight_full);
    assign auto_in_a_ready = w_aq_enq_ready && !w_gate;

    tl_buffer_cfg_queue #(
        .WIDTH (A_W),
        .DEPTH (A_DEPTH),
        .FLOW  (A_FLOW),
        .PIPE  (A_PIPE),
        .CNT_W (A_CNT_W)
    ) u_a_queue (
        .clock     (clock),
        .reset     (reset),
        .enq_valid (auto_in_a_valid && !w_gate),
        .enq_ready (w_aq_enq_ready),
        .enq_bits  (w_a_enq_bits),
        .deq_valid (auto_out_a_valid),
        .deq_ready (auto_out_a_ready),
        .deq_bits  (w_a_deq_bits),
        .count     (a_count)
    );

    tl_buffer_cfg_queue #(
        .WIDTH (D_W),
        .DEPTH (D_DEPTH),
        .FLOW  (D_FLOW),
        .PIPE  (D_PIPE),
        .CNT_W (D_CNT_W)
    ) u_d_queue (
        .clock     (clock),
        .reset     (reset),
        .enq_valid (auto_out_d_valid),
        .enq_ready (auto_out_d_ready),
        .enq_bits  (w_d_enq_bits),
        .deq_valid (auto_in_d_valid),
        .deq_ready (auto_in_d_ready),
        .deq_bits  (w_d_deq_bits),
        .count     (d_count)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_a_left   <= '0;
            r_d_left   <= '0;
            r_inflight <= '0;
            r_idle     <= 1'b1;
        end else begin
            if (w_a_fire) begin
                r_a_left <= w_a_first ? w_a_m1 : r_a_left - 1'b1;
            end
            if (w_d_fire) begin
                r_d_left <= w_d_first ? w_d_m1 : r_d_left - 1'b1;
            end
            if (w_inc && !w_dec) begin
                r_inflight <= r_inflight + 1'b1;
            end else if (!w_inc && w_dec) begin
                r_inflight <= r_inflight - 1'b1;
            end
            r_idle <= (a_count == '0) && (d_count == '0) && (r_inflight == '0) && w_a_first;
        end
    end

    assign inflight = r_inflight;
    assign idle     = r_idle;
endmodule
`default_nettype wire

// File: tb/tb_tl_buffer_cfg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tl_buffer_cfg
//  Purpose  : Self-checking bench for tl_buffer_cfg. u_dut is a buffered
//             instance (A_DEPTH 3, A_PIPE, MAX_INFLIGHT 2); u_pt has a
//             combinational A path and a flow-through D queue.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tl_buffer_cfg;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [2:0]  param;
        logic [3:0]  size;
        logic        source;
        logic [31:0] address;
        logic [7:0]  mask;
        logic [63:0] data;
        logic        corrupt;
    } a_t;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [1:0]  param;
        logic [3:0]  size;
        logic        source;
        logic [2:0]  sink;
        logic        denied;
        logic [63:0] data;
        logic        corrupt;
    } d_t;

    typedef struct {
        logic [2:0]  op;
        logic [3:0]  sz;
        logic [31:0] addr;
        logic [63:0] data;
        logic        oa_rdy;
        logic        exp_rdy;
        logic        d_vld;
        logic [2:0]  d_op;
        logic [63:0] d_data;
    } vec_t;

    logic clock;
    logic reset;

    // u_dut signals
    a_t         ia, oa;
    d_t         od, id;
    logic       ia_valid, ia_ready, oa_valid, oa_ready;
    logic       od_valid, od_ready, id_valid, id_ready;
    logic       drain_req, idle;
    logic [1:0] inflight, a_count, d_count;

    // u_pt signals
    a_t         pia, poa;
    d_t         pod, pid;
    logic       pia_valid, pia_ready, poa_valid, poa_ready;
    logic       pod_valid, pod_ready, pid_valid, pid_ready;
    logic       pdrain, pidle;
    logic [2:0] pinflight;
    logic       pa_count;
    logic [1:0] pd_count;

    int nchecks = 0;
    int nerr    = 0;
    int a_pops  = 0;
    a_t a_sb[$];
    d_t d_sb[$];

    tl_buffer_cfg #(
        .A_DEPTH(3), .D_DEPTH(2), .A_PIPE(1), .MAX_INFLIGHT(2)
    ) u_dut (
        .clock(clock), .reset(reset),
        .auto_in_a_valid(ia_valid), .auto_in_a_ready(ia_ready),
        .auto_in_a_bits_opcode(ia.opcode), .auto_in_a_bits_param(ia.param),
        .auto_in_a_bits_size(ia.size), .auto_in_a_bits_source(ia.source),
        .auto_in_a_bits_address(ia.address), .auto_in_a_bits_mask(ia.mask),
        .auto_in_a_bits_data(ia.data), .auto_in_a_bits_corrupt(ia.corrupt),
        .auto_in_d_valid(id_valid), .auto_in_d_ready(id_ready),
        .auto_in_d_bits_opcode(id.opcode), .auto_in_d_bits_param(id.param),
        .auto_in_d_bits_size(id.size), .auto_in_d_bits_source(id.source),
        .auto_in_d_bits_sink(id.sink), .auto_in_d_bits_denied(id.denied),
        .auto_in_d_bits_data(id.data), .auto_in_d_bits_corrupt(id.corrupt),
        .auto_out_a_valid(oa_valid), .auto_out_a_ready(oa_ready),
        .auto_out_a_bits_opcode(oa.opcode), .auto_out_a_bits_param(oa.param),
        .auto_out_a_bits_size(oa.size), .auto_out_a_bits_source(oa.source),
        .auto_out_a_bits_address(oa.address), .auto_out_a_bits_mask(oa.mask),
        .auto_out_a_bits_data(oa.data), .auto_out_a_bits_corrupt(oa.corrupt),
        .auto_out_d_valid(od_valid), .auto_out_d_ready(od_ready),
        .auto_out_d_bits_opcode(od.opcode), .auto_out_d_bits_param(od.param),
        .auto_out_d_bits_size(od.size), .auto_out_d_bits_source(od.source),
        .auto_out_d_bits_sink(od.sink), .auto_out_d_bits_denied(od.denied),
        .auto_out_d_bits_data(od.data), .auto_out_d_bits_corrupt(od.corrupt),
        .drain_req(drain_req), .idle(idle), .inflight(inflight),
        .a_count(a_count), .d_count(d_count)
    );

    tl_buffer_cfg #(
        .A_DEPTH(0), .D_DEPTH(2), .D_FLOW(1)
    ) u_pt (
        .clock(clock), .reset(reset),
        .auto_in_a_valid(pia_valid), .auto_in_a_ready(pia_ready),
        .auto_in_a_bits_opcode(pia.opcode), .auto_in_a_bits_param(pia.param),
        .auto_in_a_bits_size(pia.size), .auto_in_a_bits_source(pia.source),
        .auto_in_a_bits_address(pia.address), .auto_in_a_bits_mask(pia.mask),
        .auto_in_a_bits_data(pia.data), .auto_in_a_bits_corrupt(pia.corrupt),
        .auto_in_d_valid(pid_valid), .auto_in_d_ready(pid_ready),
        .auto_in_d_bits_opcode(pid.opcode), .auto_in_d_bits_param(pid.param),
        .auto_in_d_bits_size(pid.size), .auto_in_d_bits_source(pid.source),
        .auto_in_d_bits_sink(pid.sink), .auto_in_d_bits_denied(pid.denied),
        .auto_in_d_bits_data(pid.data), .auto_in_d_bits_corrupt(pid.corrupt),
        .auto_out_a_valid(poa_valid), .auto_out_a_ready(poa_ready),
        .auto_out_a_bits_opcode(poa.opcode), .auto_out_a_bits_param(poa.param),
        .auto_out_a_bits_size(poa.size), .auto_out_a_bits_source(poa.source),
        .auto_out_a_bits_address(poa.address), .auto_out_a_bits_mask(poa.mask),
        .auto_out_a_bits_data(poa.data), .auto_out_a_bits_corrupt(poa.corrupt),
        .auto_out_d_valid(pod_valid), .auto_out_d_ready(pod_ready),
        .auto_out_d_bits_opcode(pod.opcode), .auto_out_d_bits_param(pod.param),
        .auto_out_d_bits_size(pod.size), .auto_out_d_bits_source(pod.source),
        .auto_out_d_bits_sink(pod.sink), .auto_out_d_bits_denied(pod.denied),
        .auto_out_d_bits_data(pod.data), .auto_out_d_bits_corrupt(pod.corrupt),
        .drain_req(pdrain), .idle(pidle), .inflight(pinflight),
        .a_count(pa_count), .d_count(pd_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: beats accepted on one side must emerge unchanged, in order.
    always @(negedge clock) begin
        if (reset) begin
            if (oa_valid && oa_ready) begin
                if (a_sb.size() == 0) chk("a_unexpected_beat", 1, 0);
                else chk("a_payload", oa, a_sb.pop_front());
                a_pops++;
            end
            if (ia_valid && ia_ready) a_sb.push_back(ia);
            if (id_valid && id_ready) begin
                if (d_sb.size() == 0) chk("d_unexpected_beat", 1, 0);
                else chk("d_payload", id, d_sb.pop_front());
            end
            if (od_valid && od_ready) d_sb.push_back(od);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present one A beat and hold it until accepted; returns just after the
    // accepting edge with valid still high so beats can run back-to-back.
    task automatic a_beat(input logic [2:0] op, input logic [3:0] sz,
                          input logic [31:0] addr, input logic [63:0] data);
        int n;
        ia.opcode = op; ia.param = 3'd0; ia.size = sz; ia.source = 1'b0;
        ia.address = addr; ia.mask = 8'hFF; ia.data = data; ia.corrupt = 1'b0;
        ia_valid = 1'b1;
        n = 0;
        @(negedge clock);
        while (!ia_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!ia_ready) chk("a_accept_timeout", 0, 1);
        tick();
    endtask

    task automatic d_beat(input logic [2:0] op, input logic [3:0] sz, input logic [63:0] data);
        int n;
        od.opcode = op; od.param = 2'd0; od.size = sz; od.source = 1'b0;
        od.sink = 3'd2; od.denied = 1'b0; od.data = data; od.corrupt = 1'b0;
        od_valid = 1'b1;
        n = 0;
        @(negedge clock);
        while (!od_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!od_ready) chk("d_accept_timeout", 0, 1);
        tick();
    endtask

    task automatic wait_sb();
        for (int n = 0; n < 100 && (a_sb.size() != 0 || d_sb.size() != 0); n++) tick();
        chk("sb_drained", a_sb.size() + d_sb.size(), 0);
    endtask

    vec_t vecs[6];

    initial begin
        int pops0;
        int exp_inf;

        vecs[0] = '{3'd4, 4'd3, 32'h0000_0100, 64'h0,                   1'b1, 1'b1, 1'b0, 3'd0, 64'h0};
        vecs[1] = '{3'd0, 4'd3, 32'h0000_0108, 64'h1111_2222_3333_4444, 1'b1, 1'b1, 1'b1, 3'd1, 64'hAAAA_0000_0000_0001};
        vecs[2] = '{3'd4, 4'd3, 32'h0000_0110, 64'h0,                   1'b0, 1'b0, 1'b1, 3'd0, 64'h0};
        vecs[3] = '{3'd4, 4'd2, 32'h0000_0118, 64'h0,                   1'b1, 1'b1, 1'b0, 3'd0, 64'h0};
        vecs[4] = '{3'd4, 4'd3, 32'h0000_0120, 64'h0,                   1'b1, 1'b1, 1'b1, 3'd1, 64'h5555_6666_7777_8888};
        vecs[5] = '{3'd1, 4'd3, 32'h0000_0128, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b1, 1'b1, 3'd1, 64'h0123_4567_89AB_CDEF};

        reset = 1'b0;
        ia = '0; od = '0; ia_valid = 0; od_valid = 0; oa_ready = 1; id_ready = 1; drain_req = 0;
        pia = '0; pod = '0; pia_valid = 0; pod_valid = 0; poa_ready = 1; pid_ready = 1; pdrain = 0;

        // ---- reset state ----
        repeat (3) @(posedge clock);
        #1;
        chk("rst_out_a_valid", oa_valid, 0);
        chk("rst_in_d_valid", id_valid, 0);
        chk("rst_idle", idle, 1);
        chk("rst_inflight", inflight, 0);
        chk("rst_a_count", a_count, 0);
        chk("rst_d_count", d_count, 0);
        reset = 1'b1;

        // ---- single Get, AccessAckData ----
        tick();
        a_beat(3'd4, 4'd3, 32'h0000_1000, 64'h0);
        ia_valid = 0;
        chk("get_out_a_valid_lat1", oa_valid, 1);
        chk("get_inflight_up", inflight, 1);
        tick();
        d_beat(3'd1, 4'd3, 64'hDEAD_BEEF_0BAD_F00D);
        od_valid = 0;
        chk("get_inflight_before_d", inflight, 1);
        tick();
        chk("get_inflight_down", inflight, 0);
        chk("get_idle_lag", idle, 0);
        tick();
        chk("get_idle_back", idle, 1);

        // ---- 8-beat PutFullData with drain raised mid-burst ----
        pops0 = a_pops;
        for (int i = 0; i < 8; i++) begin
            a_beat(3'd0, 4'd6, 32'h0000_2000, 64'hC0DE_0000_0000_0000 + 64'(i));
            if (i == 1) drain_req = 1'b1;
        end
        ia.opcode = 3'd4; ia.size = 4'd4; ia.address = 32'h0000_3000;
        repeat (3) begin
            @(negedge clock);
            chk("drain_stall_ready", ia_ready, 0);
        end
        @(posedge clock);
        #1;
        drain_req = 1'b0;
        a_beat(3'd4, 4'd4, 32'h0000_3000, 64'h0);
        ia_valid = 0;
        wait_sb();
        chk("drain_beats_out", a_pops - pops0, 9);
        chk("drain_inflight", inflight, 2);
        d_beat(3'd0, 4'd6, 64'h0);
        od_valid = 0;
        tick(); tick();
        chk("put_ack_inflight", inflight, 1);
        d_beat(3'd1, 4'd4, 64'h0000_0000_BEA7_0000);
        d_beat(3'd1, 4'd4, 64'h0000_0000_BEA7_0001);
        od_valid = 0;
        chk("d_multi_mid", inflight, 1);
        tick();
        chk("d_multi_last", inflight, 0);

        // ---- inflight limit with D stalled ----
        a_beat(3'd4, 4'd3, 32'h0000_4000, 64'h0);
        a_beat(3'd4, 4'd3, 32'h0000_4008, 64'h0);
        ia.address = 32'h0000_4010;
        @(negedge clock);
        chk("limit_block", ia_ready, 0);
        chk("limit_inflight", inflight, 2);
        @(posedge clock);
        #1;
        id_ready = 1'b0;
        d_beat(3'd0, 4'd3, 64'h0);
        od_valid = 0;
        @(negedge clock);
        chk("limit_still_block", ia_ready, 0);
        chk("limit_d_pending", id_valid, 1);
        @(posedge clock);
        #1;
        id_ready = 1'b1;
        #1;
        chk("limit_release_same_cycle", ia_ready, 1);
        tick();
        ia_valid = 0;
        chk("limit_inflight_held", inflight, 2);
        d_beat(3'd1, 4'd3, 64'h0000_0000_0000_4008);
        d_beat(3'd1, 4'd3, 64'h0000_0000_0000_4010);
        od_valid = 0;
        tick(); tick();
        chk("limit_drained", inflight, 0);
        wait_sb();

        // ---- full A queue, pipe mode, pointer wrap ----
        oa_ready = 1'b0;
        for (int i = 0; i < 3; i++) a_beat(3'd0, 4'd6, 32'h0000_5000, 64'h5000 + 64'(i));
        chk("pipe_full_count", a_count, 3);
        ia.data = 64'h5003;
        @(negedge clock);
        chk("pipe_full_block", ia_ready, 0);
        @(posedge clock);
        #1;
        oa_ready = 1'b1;
        #1;
        chk("pipe_ready_when_deq", ia_ready, 1);
        for (int i = 3; i < 8; i++) begin
            a_beat(3'd0, 4'd6, 32'h0000_5000, 64'h5000 + 64'(i));
            chk("pipe_count_steady", a_count, 3);
        end
        ia_valid = 0;
        wait_sb();
        chk("pipe_drain_count", a_count, 0);
        d_beat(3'd0, 4'd6, 64'h0);
        od_valid = 0;
        tick(); tick();
        chk("pipe_inflight", inflight, 0);

        // ---- asynchronous reset mid-burst ----
        oa_ready = 1'b0;
        a_beat(3'd0, 4'd6, 32'h0000_6000, 64'h6000);
        a_beat(3'd0, 4'd6, 32'h0000_6000, 64'h6001);
        chk("rst2_pre_count", a_count, 2);
        #2;
        reset = 1'b0;
        #1;
        chk("rst2_out_a_valid", oa_valid, 0);
        chk("rst2_a_count", a_count, 0);
        chk("rst2_idle", idle, 1);
        chk("rst2_inflight", inflight, 0);
        chk("rst2_in_d_valid", id_valid, 0);
        ia_valid = 0;
        oa_ready = 1'b1;
        a_sb.delete();
        d_sb.delete();
        @(posedge clock);
        #1;
        reset = 1'b1;
        a_beat(3'd4, 4'd3, 32'h0000_7000, 64'h0);
        ia_valid = 0;
        chk("rst2_first_beat_start", inflight, 1);
        d_beat(3'd1, 4'd3, 64'h7000);
        od_valid = 0;
        tick(); tick();
        chk("rst2_inflight_done", inflight, 0);
        wait_sb();

        // ---- passthrough instance: table-driven ----
        exp_inf = 0;
        for (int i = 0; i < 6; i++) begin
            pia.opcode = vecs[i].op; pia.param = 3'd0; pia.size = vecs[i].sz; pia.source = 1'b1;
            pia.address = vecs[i].addr; pia.mask = 8'hF0; pia.data = vecs[i].data; pia.corrupt = 1'b0;
            pia_valid = 1'b1;
            poa_ready = vecs[i].oa_rdy;
            pod.opcode = vecs[i].d_op; pod.param = 2'd1; pod.size = 4'd3; pod.source = 1'b1;
            pod.sink = 3'd5; pod.denied = 1'b0; pod.data = vecs[i].d_data; pod.corrupt = 1'b0;
            pod_valid = vecs[i].d_vld;
            pid_ready = 1'b1;
            #1;
            chk("pt_out_a_valid", poa_valid, 1);
            chk("pt_out_a_bits", poa, pia);
            chk("pt_in_a_ready", pia_ready, vecs[i].exp_rdy);
            chk("pt_a_count", pa_count, 0);
            chk("pt_in_d_valid", pid_valid, vecs[i].d_vld);
            if (vecs[i].d_vld) chk("pt_in_d_bits", pid, pod);
            if (vecs[i].exp_rdy) exp_inf++;
            if (vecs[i].d_vld) exp_inf--;
            tick();
            chk("pt_inflight", pinflight, exp_inf);
            chk("pt_d_count", pd_count, 0);
        end
        pia_valid = 0;
        pod_valid = 0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tl_buffer_cfg.md
Name: tl_buffer_cfg

Overview:
Parametrised TileLink-UL/UH buffer inserted between a client port (auto_in) and a manager port (auto_out). It provides independently sized and moded A and D queues. It also tracks outstanding transactions with beat-accurate message framing, and adds a drain/quiesce control so clock or reset domains can be switched safely. It is the configurable successor to the fixed two-queue TL buffer and is used on crossbar-to-peripheral and tile-to-bus edges.

Parameters:
ADDR_W, 32, A address width
DATA_W, 64, data width; power of 2, >= 8; BEAT_LG = log2(DATA_W/8)
SOURCE_W, 1, source id width
SINK_W, 3, sink id width
SIZE_W, 4, size field width
A_DEPTH, 2, A queue entries; 0 = combinational passthrough
D_DEPTH, 2, D queue entries; 0 = combinational passthrough
A_FLOW, 0, 1 = enq may bypass to deq in the same cycle when empty
D_FLOW, 0, same for D
A_PIPE, 0, 1 = enq_ready also true when full and deq fires this cycle
D_PIPE, 0, same for D
MAX_INFLIGHT, 4, outstanding message limit; A is back-pressured at the limit

Ports:
clock  in  1  single clock
reset  in  1  asynchronous, active-low reset
auto_in_a_valid/ready  in/out  1  client A handshake
auto_in_a_bits_{opcode 3, param 3, size SIZE_W, source SOURCE_W, address ADDR_W, mask DATA_W/8, data DATA_W, corrupt 1}  in  client A payload
auto_in_d_valid/ready  out/in  1  client D handshake
auto_in_d_bits_{opcode 3, param 2, size SIZE_W, source SOURCE_W, sink SINK_W, denied 1, data DATA_W, corrupt 1}  out  client D payload
auto_out_a_*  mirror of auto_in_a_* with directions reversed  manager A
auto_out_d_*  mirror of auto_in_d_* with directions reversed  manager D
drain_req  in  1  stop accepting new A messages
idle  out  1  no queued beats and inflight == 0
inflight  out  clog2(MAX_INFLIGHT+1)  messages awaiting D completion
a_count  out  clog2(A_DEPTH+1)  A queue occupancy (0 if A_DEPTH = 0)
d_count  out  clog2(D_DEPTH+1)  D queue occupancy

Behaviour:
- Reset (reset == 0, async assert, sync deassert handled upstream):
  - queues empty; pointers, counts, inflight and beat counters = 0
  - auto_out_a_valid = 0, auto_in_d_valid = 0, idle = 1
- Queues are FIFOs with payload passed unmodified.
  - Latency 1 cycle enq->deq when FLOW = 0; 0 cycles when FLOW = 1 and empty.
  - enq_ready = !full, or (full && deq_ready) when PIPE = 1.
  - Simultaneous enq+deq leaves the count unchanged; pointers wrap modulo DEPTH (non-power-of-2 depths are legal).
  - DEPTH = 0: wires only; count outputs 0.
- A beat framing:
  - An A message has data when opcode <= 3.
  - Beats = 1 if no data or size <= BEAT_LG, else 2^(size - BEAT_LG).
  - A first-beat flag is held in a beat counter on the client side.
- D beat framing: data when opcode[0] == 1; same beat formula. inflight decrements on the last D beat accepted at auto_in_d.
- inflight increments on the first A beat accepted at auto_in_a.
- Same-cycle increment and decrement leaves inflight unchanged. Decrement at 0 is an error: saturate at 0 and do not underflow.
- A admission gate, applied to the first beat only:
  - auto_in_a_ready = q_enq_ready && !(first_beat && (drain_req || inflight == MAX_INFLIGHT)).
  - Beats after the first are never gated, so bursts are never split by drain.
- drain_req asserted mid-burst: the burst completes, then further first beats stall.
- idle = (a_count == 0) && (d_count == 0) && inflight == 0 && A beat counter at first beat. idle is registered (1-cycle lag).
- auto_out_d_ready comes only from D queue enq_ready; the D channel is never gated by drain.

Test Plan:
- Defaults, single Get (size 3) -> auto_out_a_valid 1 cycle after accept; inflight 1 -> 0 on the AccessAckData beat; idle returns 1 one cycle later.
- PutFullData size 6 (8 beats) with drain_req raised after beat 2 -> all 8 beats emerge on auto_out_a; the next Get stalls (a_ready = 0) until drain_req drops.
- MAX_INFLIGHT = 2: issue 3 Gets while D is stalled -> third a_ready = 0; release one AccessAck -> third accepted in the same cycle as the decrement; inflight stays 2.
- A_DEPTH = 3, A_PIPE = 1, auto_out_a_ready held 0 -> a_count saturates at 3 and a_ready = 0. Raise ready with in_a_valid = 1 -> enq and deq in the same cycle; a_count stays 3 while pointers wrap.
- A_DEPTH = 0, D_FLOW = 1 -> A combinational passthrough; D beat visible on auto_in_d the same cycle it arrives at auto_out_d when the queue is empty.
- Assert reset low mid-burst with 2 entries queued -> outputs go valid = 0, counts = 0, idle = 1 immediately (asynchronously); after release, the first A beat is treated as a message start.
